// File: rtl/fetch_stage.sv
// IF stage of the pipelined miniRV core: owns the PC, addresses the instruction ROM
// and registers the fetched word into IF/ID, honouring EX redirects and load-use stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          IROM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               npc_op,
    input  logic [31:0]        npc_bj,
    output logic [IROM_AW-1:0] irom_addr,
    input  logic [31:0]        irom_inst,
    output logic [31:0]        if_pc,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic [31:0]        id_inst,
    output logic [15:0]        flush_cnt
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect beats stall so a squashed wrong-path instruction can never be held.
    always_comb begin
        pc_d        = pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_pc4_d    = id_pc4_q;
        id_inst_d   = id_inst_q;
        flush_cnt_d = flush_cnt_q;
        if (npc_op) begin
            pc_d        = {npc_bj[31:2], 2'b00};
            id_valid_d  = 1'b0;
            id_pc_d     = 32'd0;
            id_pc4_d    = 32'd0;
            id_inst_d   = NOP_INST;
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else if (!stall) begin
            pc_d       = pc_plus4;
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_inst_d  = irom_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'd0;
            id_pc4_q    <= 32'd0;
            id_inst_q   <= NOP_INST;
            flush_cnt_q <= 16'd0;
        end else begin
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
            id_inst_q   <= id_inst_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ROM address truncates the PC, so fetches beyond the ROM size wrap around.
    assign irom_addr = pc_q[IROM_AW+1:2];
    assign if_pc     = pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;
    assign id_inst   = id_inst_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model pushes expected state per
// driven cycle, popped and compared one edge later, plus directed constant checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        npc_op = 1'b0;
    logic [31:0] npc_bj = 32'd0;
    logic [13:0] irom_addr;
    logic [31:0] irom_inst;
    logic [31:0] if_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic [15:0] flush_cnt;

    // ROM word[k] = 0x1000_0000 + k
    assign irom_inst = 32'h1000_0000 + {18'd0, irom_addr};

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013),
        .IROM_AW (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .npc_op   (npc_op),
        .npc_bj   (npc_bj),
        .irom_addr(irom_addr),
        .irom_inst(irom_inst),
        .if_pc    (if_pc),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .id_inst  (id_inst),
        .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] idpc;
        logic [31:0] idpc4;
        logic [31:0] inst;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc    = 32'd0;
    logic        m_valid = 1'b0;
    logic [31:0] m_idpc  = 32'd0;
    logic [31:0] m_idpc4 = 32'd0;
    logic [31:0] m_inst  = 32'h13;
    logic [15:0] m_fc    = 16'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + {18'd0, pc[15:2]};
    endfunction

    // Drive one cycle, predict, push; after the edge pop and compare every output.
    task automatic step(input logic r, input logic op, input logic st, input logic [31:0] bj);
        exp_t e;
        rst = r; npc_op = op; stall = st; npc_bj = bj;
        if (r) begin
            m_pc = 32'd0; m_valid = 1'b0; m_idpc = 32'd0; m_idpc4 = 32'd0;
            m_inst = 32'h13; m_fc = 16'd0;
        end else if (op) begin
            m_pc = {bj[31:2], 2'b00}; m_valid = 1'b0; m_idpc = 32'd0; m_idpc4 = 32'd0;
            m_inst = 32'h13; m_fc = m_fc + 16'd1;
        end else if (!st) begin
            m_valid = 1'b1; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
            m_inst = rom_word(m_pc); m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.valid = m_valid; e.idpc = m_idpc; e.idpc4 = m_idpc4;
        e.inst = m_inst; e.fc = m_fc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("if_pc", if_pc, e.pc);
        check("irom_addr", {18'd0, irom_addr}, {18'd0, e.pc[15:2]});
        check("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
        check("id_pc", id_pc, e.idpc);
        check("id_pc4", id_pc4, e.idpc4);
        check("id_inst", id_inst, e.inst);
        check("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.fc});
        rst = 1'b0; npc_op = 1'b0; stall = 1'b0;
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_inst", id_inst, 32'h0000_0013);
        check("rst_pc", if_pc, 32'd0);

        step(0, 0, 0, 0);
        check("run1_valid", {31'd0, id_valid}, 32'd1);
        check("run1_idpc", id_pc, 32'd0);
        check("run1_inst", id_inst, 32'h1000_0000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("run3_idpc", id_pc, 32'd8);
        check("run3_idpc4", id_pc4, 32'd12);
        check("run3_pc", if_pc, 32'd12);

        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("stall_pc", if_pc, 32'h10);
        check("stall_idpc", id_pc, 32'h0C);
        step(0, 0, 0, 0);
        check("unstall_idpc", id_pc, 32'h10);
        check("unstall_pc", if_pc, 32'h14);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("pre_redir_pc", if_pc, 32'h20);
        step(0, 1, 0, 32'h0000_0103);
        check("redir_pc", if_pc, 32'h100);
        check("redir_valid", {31'd0, id_valid}, 32'd0);
        check("redir_inst", id_inst, 32'h0000_0013);
        check("redir_fc", {16'd0, flush_cnt}, 32'd1);
        step(0, 0, 0, 0);
        check("redir_idpc", id_pc, 32'h100);

        step(0, 1, 1, 32'h40);
        check("opstall_pc", if_pc, 32'h40);
        check("opstall_valid", {31'd0, id_valid}, 32'd0);

        step(0, 1, 0, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("wrap_pc", if_pc, 32'd0);
        check("wrap_idpc4", id_pc4, 32'd0);
        check("wrap_idpc", id_pc, 32'hFFFF_FFFC);

        // back-to-back redirects keep IF/ID a bubble
        step(0, 1, 0, 32'h200);
        step(0, 1, 0, 32'h300);
        check("b2b_valid", {31'd0, id_valid}, 32'd0);

        for (int i = 0; i < 40; i++)
            step(0, ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 255) << 2);

        step(1, 0, 0, 0);
        for (int i = 0; i < 65535; i++) step(0, 1, 0, 32'h400);
        check("fc_max", {16'd0, flush_cnt}, 32'h0000_FFFF);
        step(0, 1, 0, 32'h400);
        check("fc_wrap", {16'd0, flush_cnt}, 32'd0);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 32'h80);
        check("rst_op_pc", if_pc, 32'd0);
        check("rst_op_valid", {31'd0, id_valid}, 32'd0);
        check("rst_op_fc", {16'd0, flush_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
